// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared byte type, default FIFO depth and a power-of-two helper
package uart_rx_fifo_pkg;
  localparam int RX_FIFO_DEPTH = 16;
  typedef logic [7:0] uart_byte_t;
  function automatic bit is_pow2(input int n);
    return n >= 2 && (n & (n - 1)) == 0;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver capture inputs plus consumer valid/ready and status outputs
interface uart_rx_fifo_if import uart_rx_fifo_pkg::*; #(parameter int DEPTH = RX_FIFO_DEPTH) ();
  uart_byte_t rx_byte;
  logic rx_done;
  uart_byte_t rd_data;
  logic rd_valid;
  logic rd_ready;
  logic [$clog2(DEPTH):0] count;
  logic almost_full;
  logic overflow;
  logic overflow_clr;
  modport master (output rx_byte, rx_done, rd_ready, overflow_clr,
                  input rd_data, rd_valid, count, almost_full, overflow);
  modport slave (input rx_byte, rx_done, rd_ready, overflow_clr,
                 output rd_data, rd_valid, count, almost_full, overflow);
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: unreset byte array with one synchronous write port and one asynchronous read port
module uart_fifo_mem import uart_rx_fifo_pkg::*; #(
  parameter int DEPTH = RX_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  uart_byte_t               i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output uart_byte_t               o_rdata
);
  uart_byte_t r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte queue fed by rising edges of the receiver done flag
module uart_rx_fifo import uart_rx_fifo_pkg::*; #(
  parameter int DEPTH       = RX_FIFO_DEPTH,
  parameter int ALMOST_FULL = DEPTH - 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0] r_count;
  logic r_done_q, r_overflow;
  logic w_wr_req, w_rd_req, w_full, w_wr_en, w_drop;
  uart_byte_t w_rdata;
  assign w_wr_req = bus.rx_done & ~r_done_q;
  assign w_rd_req = bus.rd_valid & bus.rd_ready;
  assign w_full   = r_count == (ADDR_W + 1)'(DEPTH);
  // a pop in the same cycle frees the slot, so a full queue still takes the write
  assign w_wr_en  = w_wr_req & (~w_full | w_rd_req);
  assign w_drop   = w_wr_req & w_full & ~w_rd_req;
  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.rx_byte),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_done_q   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done_q   <= bus.rx_done;
      r_wr_ptr   <= r_wr_ptr + ADDR_W'(w_wr_en);
      r_rd_ptr   <= r_rd_ptr + ADDR_W'(w_rd_req);
      r_count    <= r_count + (ADDR_W + 1)'(w_wr_en) - (ADDR_W + 1)'(w_rd_req);
      r_overflow <= w_drop | (r_overflow & ~bus.overflow_clr);
      assert (r_count <= (ADDR_W + 1)'(DEPTH));
      assert (!(w_rd_req && r_count == '0));
    end
  // storage is unreset, so the head byte is masked to zero while empty
  assign bus.rd_data     = bus.rd_valid ? w_rdata : 8'h00;
  assign bus.rd_valid    = r_count != '0;
  assign bus.count       = r_count;
  assign bus.almost_full = r_count >= (ADDR_W + 1)'(ALMOST_FULL);
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks against a queue-based reference model of the byte FIFO
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  uart_byte_t q[$];
  logic m_ovf = 1'b0;
  logic m_prev = 1'b0;
  uart_rx_fifo_if #(.DEPTH(16)) bus ();
  uart_rx_fifo #(.DEPTH(16), .ALMOST_FULL(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input logic d, input uart_byte_t b, input logic r, input logic c);
    logic wr, rd, drop;
    bus.rx_done = d;
    bus.rx_byte = b;
    bus.rd_ready = r;
    bus.overflow_clr = c;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_prev = 1'b0;
    end else begin
      wr = d & ~m_prev;
      rd = (q.size() != 0) & r;
      drop = wr && q.size() == 16 && !rd;
      if (rd) void'(q.pop_front());
      if (wr && !drop) q.push_back(b);
      m_ovf = drop | (m_ovf & ~c);
      m_prev = d;
    end
    #1;
  endtask

  task automatic push(input uart_byte_t b);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checks += 5;
    if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.rd_valid); end
    if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
    if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b want=0", bus.almost_full); end
    if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", bus.rd_data); end
  endtask

  task automatic test_single;
    push(8'hA5);
    checks += 3;
    if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", bus.rd_valid); end
    if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h want=a5", bus.rd_data); end
    if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d want=1", bus.count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks += 2;
    if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b want=0", bus.rd_valid); end
    if (bus.count !== 5'd0) begin errors++; $display("FAIL single_pop_count got=%0d want=0", bus.count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 5'd0) begin errors++; $display("FAIL empty_ready_count got=%0d want=0", bus.count); end
  endtask

  task automatic test_held_done;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks += 2;
    if (bus.count !== 5'd1) begin errors++; $display("FAIL held_count got=%0d want=1", bus.count); end
    if (bus.rd_data !== 8'h3C) begin errors++; $display("FAIL held_data got=%h want=3c", bus.rd_data); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_fill_wrap;
    int pushed = 0;
    int n = 0;
    logic d, r;
    for (int i = 0; i < 16; i++) begin
      push(uart_byte_t'(i));
      checks += 2;
      if (bus.count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count i=%0d got=%0d want=%0d", i, bus.count, i + 1); end
      if (bus.almost_full !== (i + 1 >= 12)) begin errors++; $display("FAIL fill_af i=%0d got=%b want=%b", i, bus.almost_full, i + 1 >= 12); end
    end
    push(8'hFF);
    checks += 2;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
    if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d want=16", bus.count); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.rd_data !== uart_byte_t'(i)) begin errors++; $display("FAIL drain_data i=%0d got=%h want=%h", i, bus.rd_data, i); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b want=0", bus.rd_valid); end
    while ((pushed < 20 || q.size() != 0) && n < 500) begin
      d = !m_prev && pushed < 20 && $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 1) == 1;
      if (d) pushed++;
      step(d, uart_byte_t'($urandom), r, 1'b0);
      n++;
      checks += 2;
      if (bus.count !== 5'(q.size())) begin errors++; $display("FAIL wrap_count got=%0d want=%0d", bus.count, q.size()); end
      if (q.size() != 0 && bus.rd_data !== q[0]) begin errors++; $display("FAIL wrap_data got=%h want=%h", bus.rd_data, q[0]); end
    end
    checks++;
    if (n >= 500) begin errors++; $display("FAIL wrap_timeout got=%0d cycles want<500", n); end
  endtask

  task automatic test_full_push_pop;
    uart_byte_t exp[16];
    logic ovf0;
    for (int i = 0; i < 16; i++) begin
      exp[i] = uart_byte_t'($urandom);
      push(exp[i]);
    end
    ovf0 = bus.overflow;
    step(1'b1, 8'h77, 1'b1, 1'b0);
    checks += 2;
    if (bus.count !== 5'd16) begin errors++; $display("FAIL fullpp_count got=%0d want=16", bus.count); end
    if (bus.overflow !== m_ovf) begin errors++; $display("FAIL fullpp_ovf got=%b want=%b (before=%b)", bus.overflow, m_ovf, ovf0); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.rd_data !== (i == 15 ? 8'h77 : exp[i + 1])) begin
        errors++; $display("FAIL fullpp_order i=%0d got=%h want=%h", i, bus.rd_data, i == 15 ? 8'h77 : exp[i + 1]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_ovf_clr_reset;
    for (int i = 0; i < 16; i++) push(uart_byte_t'($urandom));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_pre got=%b want=0", bus.overflow); end
    step(1'b1, 8'h99, 1'b0, 1'b1);
    checks += 2;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_race got=%b want=1", bus.overflow); end
    if (bus.count !== 5'd16) begin errors++; $display("FAIL clr_race_count got=%0d want=16", bus.count); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got=%b want=0", bus.overflow); end
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 5'd5) begin errors++; $display("FAIL pre_rst_count got=%0d want=5", bus.count); end
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checks += 2;
    if (bus.count !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", bus.count); end
    if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", bus.rd_valid); end
    push(8'h5A);
    checks++;
    if (bus.rd_data !== 8'h5A) begin errors++; $display("FAIL post_rst_data got=%h want=5a", bus.rd_data); end
  endtask

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_byte = 8'h00;
    bus.rd_ready = 1'b0;
    bus.overflow_clr = 1'b0;
    test_reset;
    test_single;
    test_held_done;
    test_fill_wrap;
    test_full_push_pop;
    test_ovf_clr_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
